// File: rtl/accum_xcel_engine.sv
// accum_xcel_engine: array-accumulate accelerator (controller + datapath).
// On go it streams `size` 32-bit words starting at `base_addr` through an
// in-order val/rdy read port, keeps up to p_max_outst reads in flight, sums
// the responses and hands the sum out on a val/rdy result port.
//
// Build option: define ACCUM_XCEL_ENGINE_SAT_EN for an unsigned saturating
// accumulator; otherwise the sum wraps modulo 2^p_nbits.
//
// state | meaning
// IDLE  | waiting for go, go_rdy=1
// FETCH | issuing reads and accepting responses
// DRAIN | all reads issued, collecting remaining responses
// DONE  | result_val=1, waiting for result_rdy
module accum_xcel_engine #(
    parameter int p_nbits      = 32,
    parameter int p_addr_nbits = 32,
    parameter int p_size_nbits = 16,
    parameter int p_max_outst  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    output logic                    go_rdy,
    input  logic [p_addr_nbits-1:0] base_addr,
    input  logic [p_size_nbits-1:0] size,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [p_addr_nbits-1:0] memreq_addr,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [p_nbits-1:0]      memresp_data,
    output logic                    result_val,
    input  logic                    result_rdy,
    output logic [p_nbits-1:0]      result_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] MAX_OUTST = 3'(p_max_outst);

    state_t                  state_q;
    logic [p_addr_nbits-1:0] base_q;
    logic [p_size_nbits-1:0] size_q;
    logic [p_size_nbits-1:0] issued_q,   issued_d;
    logic [p_size_nbits-1:0] received_q, received_d;
    logic [2:0]              outst_q,    outst_d;
    logic [p_nbits-1:0]      acc_q,      acc_d;
    logic                    req_fire;
    logic                    resp_fire;

    // Port outputs are decoded purely from registered state and counters.
    always_comb begin
        go_rdy      = (state_q == ST_IDLE);
        busy        = (state_q != ST_IDLE);
        memresp_rdy = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        result_val  = (state_q == ST_DONE);
        result_data = acc_q;
        memreq_val  = (state_q == ST_FETCH) && (issued_q < size_q) && (outst_q < MAX_OUTST);
        memreq_addr = base_q + (p_addr_nbits'(issued_q) << 2);
    end

    // Next values of the counters and accumulator for this cycle's handshakes.
    always_comb begin
        req_fire   = memreq_val & memreq_rdy;
        resp_fire  = memresp_val & memresp_rdy;
        issued_d   = issued_q + p_size_nbits'(req_fire);
        received_d = received_q + p_size_nbits'(resp_fire);
        outst_d    = outst_q;
        case ({req_fire, resp_fire})
            2'b10:   outst_d = outst_q + 3'd1;
            2'b01:   outst_d = outst_q - 3'd1;
            default: outst_d = outst_q;
        endcase
        acc_d = acc_q;
        if (resp_fire) begin
`ifdef ACCUM_XCEL_ENGINE_SAT_EN
            // Unsigned saturation: once at all-ones any further add carries out again.
            logic [p_nbits:0] sum_ext;
            sum_ext = {1'b0, acc_q} + {1'b0, memresp_data};
            acc_d   = sum_ext[p_nbits] ? {p_nbits{1'b1}} : sum_ext[p_nbits-1:0];
`else
            acc_d = acc_q + memresp_data;
`endif
        end
    end

    // Controller FSM with job registers and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        base_q     <= base_addr;
                        size_q     <= size;
                        issued_q   <= '0;
                        received_q <= '0;
                        outst_q    <= '0;
                        acc_q      <= '0;
                        state_q    <= ST_FETCH;
                    end
                end
                // An empty job (size 0) spends one cycle here with no requests and
                // then leaves for DONE, keeping go-to-result at size+2 cycles.
                ST_FETCH, ST_DRAIN: begin
                    issued_q   <= issued_d;
                    received_q <= received_d;
                    outst_q    <= outst_d;
                    acc_q      <= acc_d;
                    if (received_d == size_q) begin
                        state_q <= ST_DONE;
                    end else if (issued_d == size_q) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    if (result_rdy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_xcel_engine.sv
// Bench for accum_xcel_engine: directed jobs, in-order memory model, and a
// scoreboard monitor that checks every request address and every result.
module tb_accum_xcel_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        go_rdy;
    logic [31:0] base_addr = '0;
    logic [15:0] size = '0;
    logic        memreq_val;
    logic        memreq_rdy = 1'b1;
    logic [31:0] memreq_addr;
    logic        memresp_val = 1'b0;
    logic        memresp_rdy;
    logic [31:0] memresp_data = '0;
    logic        result_val;
    logic        result_rdy = 1'b1;
    logic [31:0] result_data;
    logic        busy;

    accum_xcel_engine dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .go_rdy      (go_rdy),
        .base_addr   (base_addr),
        .size        (size),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_addr (memreq_addr),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_data(memresp_data),
        .result_val  (result_val),
        .result_rdy  (result_rdy),
        .result_data (result_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          req_fire_cnt = 0;
    logic        mem_stall = 1'b0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rq [$];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_res_q [$];
    logic [31:0] jd [$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and memory request capture, sampled at the active edge.
    always @(posedge clk) begin
        if (rst) begin
            rq.delete();
            exp_addr_q.delete();
            exp_res_q.delete();
            hold_v = 1'b0;
        end else begin
            if (memresp_val && memresp_rdy && rq.size() > 0) void'(rq.pop_front());
            if (memreq_val && memreq_rdy) begin
                req_fire_cnt++;
                if (exp_addr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr 0x%0h, expected no request", memreq_addr);
                end else begin
                    chk("req_addr", 64'(memreq_addr), 64'(exp_addr_q.pop_front()));
                end
                rq.push_back(mem.exists(memreq_addr) ? mem[memreq_addr] : 32'h0);
            end
            if (result_val) begin
                if (hold_v) chk("result_hold", 64'(result_data), 64'(hold_d));
                if (result_rdy) begin
                    hold_v = 1'b0;
                    if (exp_res_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: data 0x%0h, expected none", result_data);
                    end else begin
                        chk("result_data", 64'(result_data), 64'(exp_res_q.pop_front()));
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = result_data;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Memory response driver: head of the in-order queue, one cycle after the request.
    always @(negedge clk) begin
        #1;
        if (rst || mem_stall || rq.size() == 0) begin
            memresp_val  = 1'b0;
            memresp_data = '0;
        end else begin
            memresp_val  = 1'b1;
            memresp_data = rq[0];
        end
    end

    task automatic issue_job(input logic [31:0] base, input logic [31:0] exp_sum);
        logic [31:0] a;
        for (int i = 0; i < jd.size(); i++) begin
            a = base + 32'(i * 4);
            mem[a] = jd[i];
            exp_addr_q.push_back(a);
        end
        exp_res_q.push_back(exp_sum);
        req_fire_cnt = 0;
        base_addr = base;
        size = 16'(jd.size());
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat, input string name);
        int k = 1;
        while (!result_val && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!result_val) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: result_val=0 after %0d cycles, expected 1", name, k);
        end else if (exp_lat > 0) begin
            chk({name, "_latency"}, 64'(k), 64'(exp_lat));
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(go_rdy && !result_val) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!(go_rdy && !result_val)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_idle_timeout: go_rdy=%0b, expected 1", name, go_rdy);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;

        // Power-on reset values.
        @(negedge clk);
        chk("rst_go_rdy", go_rdy, 1);
        chk("rst_memreq_val", memreq_val, 0);
        chk("rst_memresp_rdy", memresp_rdy, 0);
        chk("rst_result_val", result_val, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of FETCH with two reads outstanding.
        mem_stall = 1'b1;
        jd = {32'h11, 32'h22, 32'h33, 32'h44};
        issue_job(32'h200, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_pre_rst_req_cnt", 64'(req_fire_cnt), 2);
        chk("t1_pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("t1_rst_go_rdy", go_rdy, 1);
        chk("t1_rst_memreq_val", memreq_val, 0);
        chk("t1_rst_result_val", result_val, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_stall = 1'b0;
        @(negedge clk);
        jd = {32'h55};
        issue_job(32'h100, 32'h55);
        wait_result(3, "t1");
        wait_idle("t1");

        // Four-word sum, memory always ready, result held until result_rdy.
        result_rdy = 1'b0;
        jd = {32'd1, 32'd2, 32'd3, 32'd4};
        issue_job(32'h1000, 32'd10);
        wait_result(6, "t2");
        @(negedge clk);
        @(negedge clk);
        chk("t2_result_held", result_val, 1);
        result_rdy = 1'b1;
        wait_idle("t2");

        // Empty job: no requests, zero result two cycles after go.
        jd.delete();
        issue_job(32'h2000, 32'd0);
        wait_result(2, "t3");
        chk("t3_no_requests", 64'(req_fire_cnt), 0);
        wait_idle("t3");

        // Response stall: two requests in flight, then the request port stays quiet.
        mem_stall = 1'b1;
        jd = {32'd10, 32'd20, 32'd30};
        issue_job(32'h300, 32'd60);
        bad = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 3 && memreq_val) bad = 1'b1;
        end
        chk("t4_req_count", 64'(req_fire_cnt), 2);
        chk("t4_req_held_off", bad, 0);
        mem_stall = 1'b0;
        wait_result(-1, "t4");
        wait_idle("t4");

        // Accumulator overflow.
        jd = {32'hFFFF_FFFF, 32'd2};
`ifdef ACCUM_XCEL_ENGINE_SAT_EN
        issue_job(32'h500, 32'hFFFF_FFFF);
`else
        issue_job(32'h500, 32'd1);
`endif
        wait_result(4, "t5");
        wait_idle("t5");

        // Stray go pulses in FETCH and DONE, result_rdy low for three cycles.
        result_rdy = 1'b0;
        jd = {32'd5, 32'd6, 32'd7};
        issue_job(32'h400, 32'd18);
        base_addr = 32'hDEAD0;
        size = 16'd9;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_result(-1, "t6");
        chk("t6_go_rdy_in_done", go_rdy, 0);
        chk("t6_busy_in_done", busy, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_result_still_val", result_val, 1);
        chk("t6_result_still_data", 64'(result_data), 64'd18);
        result_rdy = 1'b1;
        @(negedge clk);
        chk("t6_idle_after_fire", go_rdy, 1);
        chk("t6_result_val_cleared", result_val, 0);
        @(negedge clk);
        chk("t6_no_stray_job", busy, 0);

        repeat (3) @(negedge clk);
        chk("sb_results_drained", 64'(exp_res_q.size()), 0);
        chk("sb_addrs_drained", 64'(exp_addr_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
